// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the register-dump state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned ADDR_W = $clog2(NREGS);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/reg_dump_fsm.sv
// Streams every register out over a valid/ready handshake, one beat per register,
// one dump per rising level of dbg_req.
module reg_dump_fsm
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_req,
    input  logic              dbg_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              dbg_valid,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_busy
);

    dbg_state_t        state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;

    // Next beat's index; its bypassed value is captured on acceptance of the current beat.
    assign rd_addr  = ADDR_W'(dbg_addr + ADDR_W'(1));
    assign dbg_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dbg_valid <= 1'b0;
            dbg_addr  <= '0;
            dbg_data  <= '0;
        end else begin
            state     <= state_n;
            dbg_valid <= valid_n;
            dbg_addr  <= addr_n;
            dbg_data  <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = dbg_addr;
        data_n  = dbg_data;
        valid_n = dbg_valid;
        case (state)
            IDLE: begin
                if (dbg_req) begin
                    state_n = SEND;
                    addr_n  = '0;
                    data_n  = '0;
                    valid_n = 1'b1;
                end
            end
            SEND: begin
                if (dbg_valid && dbg_ready) begin
                    if (dbg_addr == LAST_IDX) begin
                        valid_n = 1'b0;
                        state_n = DONE;
                    end else begin
                        addr_n = rd_addr;
                        data_n = rd_data;
                    end
                end
            end
            DONE: begin
                if (!dbg_req) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// 8 x 16-bit register file with write-through bypass, latched zero flag and a
// debug dump port; R0 reads as zero.
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic              zero_in,
    output logic              zero_flag,
    input  logic              dbg_req,
    input  logic              dbg_ready,
    output logic              dbg_valid,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_busy
);

    logic [DATA_W-1:0] regs [1:NREGS-1];
    logic [DATA_W-1:0] view [NREGS];
    logic [ADDR_W-1:0] dump_addr;

    // Bypassed view of the array: a same-cycle write is visible to every reader.
    always_comb begin
        view[0] = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            view[i] = (reg_write && (rd == ADDR_W'(i))) ? wr_data : regs[i];
        end
    end

    assign rd_data1 = view[rs1];
    assign rd_data2 = view[rs2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (rd != '0)) begin
            regs[rd] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag <= 1'b0;
        end else if (flag_we) begin
            zero_flag <= zero_in;
        end
    end

    reg_dump_fsm u_dump (
        .clk       (clk),
        .reset     (reset),
        .dbg_req   (dbg_req),
        .dbg_ready (dbg_ready),
        .rd_data   (view[dump_addr]),
        .rd_addr   (dump_addr),
        .dbg_valid (dbg_valid),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_busy  (dbg_busy)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expectations from a behavioural
// model, a negedge monitor pops and compares.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [15:0] rd_data1, rd_data2, wr_data = '0;
    logic        reg_write = 1'b0, flag_we = 1'b0, zero_in = 1'b0, zero_flag;
    logic        dbg_req = 1'b0, dbg_ready = 1'b0, dbg_valid, dbg_busy;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    reg_file dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .reg_write(reg_write), .rd(rd), .wr_data(wr_data),
        .flag_we(flag_we), .zero_in(zero_in), .zero_flag(zero_flag),
        .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        zf;
        logic        busy;
        logic        valid;
    } cyc_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } beat_t;

    localparam int P_IDLE = 0;
    localparam int P_SEND = 1;
    localparam int P_DONE = 2;

    cyc_t        cq[$];
    beat_t       bq[$];
    logic [15:0] m_regs [8];
    logic        m_zf;
    int          phase;
    int          nb;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [2:0] a, input logic we,
                                          input logic [2:0] d, input logic [15:0] wd);
        if (a == 3'd0) return 16'h0000;
        if (we && d == a) return wd;
        return m_regs[a];
    endfunction

    always @(negedge clk) begin
        if (cq.size() > 0) begin
            cyc_t c;
            c = cq.pop_front();
            chk("rd_data1", 32'(rd_data1), 32'(c.rd1));
            chk("rd_data2", 32'(rd_data2), 32'(c.rd2));
            chk("zero_flag", 32'(zero_flag), 32'(c.zf));
            chk("dbg_busy", 32'(dbg_busy), 32'(c.busy));
            chk("dbg_valid", 32'(dbg_valid), 32'(c.valid));
        end
        if (dbg_valid === 1'b1 && dbg_ready === 1'b1) begin
            if (bq.size() == 0) begin
                chk("beat_unexpected", 32'(dbg_valid), 32'(0));
            end else begin
                beat_t b;
                b = bq.pop_front();
                chk("dbg_addr", 32'(dbg_addr), 32'(b.addr));
                chk("dbg_data", 32'(dbg_data), 32'(b.data));
            end
        end
    end

    task automatic step(input logic rst, input logic we, input logic [2:0] d,
                        input logic [15:0] wd, input logic [2:0] a1, input logic [2:0] a2,
                        input logic fwe, input logic zin, input logic req, input logic rdy);
        cyc_t e;
        reset = rst; reg_write = we; rd = d; wr_data = wd; rs1 = a1; rs2 = a2;
        flag_we = fwe; zero_in = zin; dbg_req = req; dbg_ready = rdy;
        e.rd1   = mread(a1, we, d, wd);
        e.rd2   = mread(a2, we, d, wd);
        e.zf    = m_zf;
        e.busy  = (phase != P_IDLE);
        e.valid = (phase == P_SEND);
        cq.push_back(e);
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 16'h0000;
            m_zf  = 1'b0;
            phase = P_IDLE;
            nb    = 0;
            bq.delete();
        end else begin
            // Beat k carries register k as seen (bypassed) when beat k-1 is accepted.
            case (phase)
                P_IDLE: if (req) begin
                    phase = P_SEND;
                    nb    = 0;
                    bq.push_back('{3'd0, 16'h0000});
                end
                P_SEND: if (rdy) begin
                    if (nb == 7) phase = P_DONE;
                    else begin
                        nb++;
                        bq.push_back('{3'(nb), mread(3'(nb), we, d, wd)});
                    end
                end
                default: if (!req) phase = P_IDLE;
            endcase
            if (we && d != 3'd0) m_regs[d] = wd;
            if (fwe) m_zf = zin;
        end
        #1;
    endtask

    task automatic idle(input logic req, input logic rdy);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, req, rdy);
    endtask

    task automatic load(input logic [2:0] d, input logic [15:0] wd);
        step(1'b0, 1'b1, d, wd, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic r_req;
        foreach (m_regs[i]) m_regs[i] = 16'h0000;
        m_zf = 1'b0; phase = P_IDLE; nb = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset clears prior writes and the flag
        for (int i = 1; i < 8; i++) load(3'(i), 16'h1000 + 16'(i));
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, 1'b0, 1'b0, 1'b0);

        // Bypass then registered read of R3
        step(1'b0, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Writes to R0 are dropped
        step(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero flag capture and hold
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full dump with ready held high
        for (int i = 1; i < 8; i++) load(3'(i), 16'(i));
        repeat (12) idle(1'b1, 1'b1);
        repeat (2) idle(1'b0, 1'b1);

        // Stall at beat 2 while R2 is overwritten, then reset mid-dump
        for (int i = 1; i < 8; i++) load(3'(i), 16'(i) * 16'h0011);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) idle(1'b0, 1'b1);

        // Randomized traffic
        r_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) r_req = ~r_req;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 r_req,
                 1'($urandom_range(0, 1)));
        end

        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("beats_outstanding", 32'(bq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
